// File: rtl/ir_decode_pkg.sv
// Shared ARM decode constants: condition codes, flag bit positions,
// instruction family numbers and the reset instruction word.
package ir_decode_pkg;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Condition field encodings (ir[31:28])
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Instruction families; the sequencer dispatches to family*8.
    // 12..14 are deliberately unused so targets stay below the fetch
    // state at 104; undefined sits at 120.
    localparam logic [3:0] FAM_DP_REG = 4'd0;
    localparam logic [3:0] FAM_DP_IMM = 4'd1;
    localparam logic [3:0] FAM_MUL    = 4'd2;
    localparam logic [3:0] FAM_MULL   = 4'd3;
    localparam logic [3:0] FAM_SWP    = 4'd4;
    localparam logic [3:0] FAM_HALF   = 4'd5;
    localparam logic [3:0] FAM_SINGLE = 4'd6;
    localparam logic [3:0] FAM_BLOCK  = 4'd7;
    localparam logic [3:0] FAM_BRANCH = 4'd8;
    localparam logic [3:0] FAM_SWI    = 4'd9;
    localparam logic [3:0] FAM_BX     = 4'd10;
    localparam logic [3:0] FAM_COPROC = 4'd11;
    localparam logic [3:0] FAM_UNDEF  = 4'd15;

    // MOV r0,r0 -- a harmless instruction to sit in ir after reset
    localparam logic [31:0] IR_RESET = 32'hE1A0_0000;

endpackage

// File: rtl/cond_eval.sv
// Evaluates an ARM condition field against {N,Z,C,V}.
// Conditions come in true/inverse pairs: cond[3:1] picks the base test
// and cond[0] inverts it. The AL/NV pair falls out as 1/0.
module cond_eval
    import ir_decode_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Base test of each condition pair
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0: base = z;                 // EQ / NE
            3'd1: base = c;                 // CS / CC
            3'd2: base = n;                 // MI / PL
            3'd3: base = v;                 // VS / VC
            3'd4: base = c & ~z;            // HI / LS
            3'd5: base = (n == v);          // GE / LT
            3'd6: base = ~z & (n == v);     // GT / LE
            default: base = 1'b1;           // AL / NV
        endcase
    end

    assign pass = base ^ cond[0];

endmodule

// File: rtl/ir_decode.sv
// Instruction register with fetch handshake, flag register and the
// combinational decode (condition pass, family, L/P/A bits) the
// microsequencer dispatches on.
module ir_decode
    import ir_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_ir,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        ld_flags,
    input  logic [3:0]  alu_flags,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic        fetch_stall,
    output logic [3:0]  flags,
    output logic [3:0]  family_number,
    output logic        COND,
    output logic        L,
    output logic        P,
    output logic        A
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0] state;
    logic       fetch_done;

    // A word is captured when memory answers a fresh request or an
    // outstanding one; ld_ir while waiting adds nothing.
    assign fetch_done  = mem_ready & ((state == IDLE) ? ld_ir : 1'b1);
    assign fetch_stall = ~mem_ready & ((state == IDLE) ? ld_ir : 1'b1);

    // Fetch FSM and instruction register; reset abandons any fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ir       <= IR_RESET;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:     if (ld_ir && !mem_ready) state <= WAIT_MEM;
                WAIT_MEM: if (mem_ready) state <= IDLE;
                default:  state <= IDLE;
            endcase
            if (fetch_done) begin
                ir       <= mem_rdata;
                ir_valid <= 1'b1;
            end
        end
    end

    // Flag register loads regardless of fetch state
    always_ff @(posedge clk) begin
        if (rst)
            flags <= 4'b0000;
        else if (ld_flags)
            flags <= alu_flags;
    end

    // Family decode, first match wins
    always_comb begin
        family_number = FAM_COPROC;
        if (ir[27:4] == 24'h12FFF1)
            family_number = FAM_BX;
        else if (ir[27:22] == 6'b000000 && ir[7:4] == 4'b1001)
            family_number = FAM_MUL;
        else if (ir[27:23] == 5'b00001 && ir[7:4] == 4'b1001)
            family_number = FAM_MULL;
        else if (ir[27:23] == 5'b00010 && ir[21:20] == 2'b00 && ir[11:4] == 8'b0000_1001)
            family_number = FAM_SWP;
        else if (ir[27:25] == 3'b000 && ir[7] && ir[4])
            family_number = FAM_HALF;
        else if (ir[27:25] == 3'b000)
            family_number = FAM_DP_REG;
        else if (ir[27:25] == 3'b001)
            family_number = FAM_DP_IMM;
        else if (ir[27:25] == 3'b011 && ir[4])
            family_number = FAM_UNDEF;
        else if (ir[27:26] == 2'b01)
            family_number = FAM_SINGLE;
        else if (ir[27:25] == 3'b100)
            family_number = FAM_BLOCK;
        else if (ir[27:25] == 3'b101)
            family_number = FAM_BRANCH;
        else if (ir[27:24] == 4'b1111)
            family_number = FAM_SWI;
    end

    assign L = ir[20];
    assign P = ir[24];
    assign A = ir[21];

    cond_eval u_cond (
        .cond  (ir[31:28]),
        .flags (flags),
        .pass  (COND)
    );

endmodule
